// File: rtl/sync_fifo.sv
// sync_fifo: single-clock byte FIFO with registered read data and occupancy counter.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in,
   output logic [DATA_W-1:0] out,
   input  logic              we,
   input  logic              re,
   output logic              empty,
   output logic              full,
   output logic [CNT_W-1:0]  counter
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   ,
   output logic              overflow,
   output logic              underflow
);
`else
);
`endif
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              wr_ok, rd_ok;
   assign empty = counter == '0;
   assign full  = counter == CNT_W'(DEPTH);
   assign rd_ok = re & ~empty;
   // a write into a full FIFO is accepted only when a read frees a slot in the same cycle
   assign wr_ok = we & (~full | rd_ok);
   always_ff @(posedge clk)
      if (wr_ok) mem[wr_ptr] <= in;
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         counter <= '0;
         out     <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (rd_ok) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
            out    <= mem[rd_ptr];
         end
         counter <= (wr_ok & ~rd_ok) ? counter + CNT_W'(1) :
                    (rd_ok & ~wr_ok) ? counter - CNT_W'(1) : counter;
      end
   end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (we & full & ~re) overflow <= 1'b1;
         if (re & empty) underflow <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo.
module tb_sync_fifo;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] in = '0;
   logic [7:0] out;
   logic       we = 1'b0;
   logic       re = 1'b0;
   logic       empty, full;
   logic [7:0] counter;
   int         checks = 0;
   int         errors = 0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic overflow, underflow;
`endif

   sync_fifo dut (
      .clk(clk), .reset(reset), .in(in), .out(out), .we(we), .re(re),
      .empty(empty), .full(full), .counter(counter)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      , .overflow(overflow), .underflow(underflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic w, input logic r, input logic [7:0] d);
      we = w;
      re = r;
      in = d;
      @(posedge clk);
      #1;
      we = 1'b0;
      re = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      checks += 4;
      if (out !== 8'h00) begin errors++; $display("FAIL reset_out got %h exp 00", out); end
      if (counter !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", counter); end
      if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
      if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      checks += 2;
      if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
      if (underflow !== 1'b0) begin errors++; $display("FAIL reset_unf got %b exp 0", underflow); end
`endif
   endtask

   task automatic test_push_pop();
      cyc(1'b1, 1'b0, 8'd1);
      checks += 2;
      if (counter !== 8'd1) begin errors++; $display("FAIL pp_cnt1 got %0d exp 1", counter); end
      if (empty !== 1'b0) begin errors++; $display("FAIL pp_empty0 got %b exp 0", empty); end
      cyc(1'b0, 1'b1, 8'd0);
      checks += 3;
      if (out !== 8'd1) begin errors++; $display("FAIL pp_out got %h exp 01", out); end
      if (counter !== 8'd0) begin errors++; $display("FAIL pp_cnt0 got %0d exp 0", counter); end
      if (empty !== 1'b1) begin errors++; $display("FAIL pp_empty1 got %b exp 1", empty); end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 8; i++) begin
         checks++;
         if (full !== 1'b0) begin errors++; $display("FAIL fill_notfull_%0d got %b exp 0", i, full); end
         cyc(1'b1, 1'b0, 8'(i));
      end
      checks += 2;
      if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
      if (counter !== 8'd8) begin errors++; $display("FAIL fill_cnt got %0d exp 8", counter); end
      cyc(1'b1, 1'b0, 8'd9);
      checks += 2;
      if (counter !== 8'd8) begin errors++; $display("FAIL ovf_cnt got %0d exp 8", counter); end
      if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", full); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
`endif
   endtask

   task automatic test_wrap();
      logic [7:0] exp_seq [7];
      exp_seq = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd10};
      cyc(1'b0, 1'b1, 8'd0);
      checks++;
      if (out !== 8'd1) begin errors++; $display("FAIL wrap_pop1 got %h exp 01", out); end
      cyc(1'b0, 1'b1, 8'd0);
      checks += 2;
      if (out !== 8'd2) begin errors++; $display("FAIL wrap_pop2 got %h exp 02", out); end
      if (counter !== 8'd6) begin errors++; $display("FAIL wrap_cnt6 got %0d exp 6", counter); end
      cyc(1'b1, 1'b0, 8'd10);
      checks++;
      if (counter !== 8'd7) begin errors++; $display("FAIL wrap_cnt7 got %0d exp 7", counter); end
      for (int i = 0; i < 7; i++) begin
         cyc(1'b0, 1'b1, 8'd0);
         checks++;
         if (out !== exp_seq[i]) begin errors++; $display("FAIL wrap_seq_%0d got %h exp %h", i, out, exp_seq[i]); end
      end
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", empty); end
   endtask

   task automatic test_empty();
      cyc(1'b0, 1'b1, 8'd0);
      checks += 2;
      if (out !== 8'd10) begin errors++; $display("FAIL unf_out got %h exp 0a", out); end
      if (counter !== 8'd0) begin errors++; $display("FAIL unf_cnt got %0d exp 0", counter); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      checks++;
      if (underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got %b exp 1", underflow); end
`endif
      cyc(1'b1, 1'b1, 8'h55);
      checks += 2;
      if (counter !== 8'd1) begin errors++; $display("FAIL erw_cnt got %0d exp 1", counter); end
      if (out !== 8'd10) begin errors++; $display("FAIL erw_out got %h exp 0a", out); end
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
      checks++;
      if (full !== 1'b1) begin errors++; $display("FAIL frw_full got %b exp 1", full); end
      cyc(1'b1, 1'b1, 8'hAA);
      checks += 2;
      if (out !== 8'h55) begin errors++; $display("FAIL frw_out got %h exp 55", out); end
      if (counter !== 8'd8) begin errors++; $display("FAIL frw_cnt got %0d exp 8", counter); end
      cyc(1'b0, 1'b1, 8'd0);
      checks++;
      if (out !== 8'h60) begin errors++; $display("FAIL frw_next got %h exp 60", out); end
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      checks += 4;
      if (counter !== 8'd0) begin errors++; $display("FAIL mrst_cnt got %0d exp 0", counter); end
      if (empty !== 1'b1) begin errors++; $display("FAIL mrst_empty got %b exp 1", empty); end
      if (full !== 1'b0) begin errors++; $display("FAIL mrst_full got %b exp 0", full); end
      if (out !== 8'h00) begin errors++; $display("FAIL mrst_out got %h exp 00", out); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL mrst_ovf got %b exp 0", overflow); end
`endif
      cyc(1'b1, 1'b0, 8'h33);
      cyc(1'b0, 1'b1, 8'd0);
      checks++;
      if (out !== 8'h33) begin errors++; $display("FAIL post_rst_out got %h exp 33", out); end
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_fill();
      test_wrap();
      test_empty();
      test_full_rw();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
